// File: rtl/operand_matcher_stream.sv
// Handshaked sparse operand matcher: pairs the mutual nonzero positions of a
// weight/activation bitmask pair and streams their dense indices NUM_LANES at a time.
module operand_matcher_stream #(
  parameter int BITMASK_LENGTH = 16,
  parameter int NUM_LANES      = 4,
  parameter int INDEX_BITWIDTH = $clog2(BITMASK_LENGTH),
  parameter int COUNT_BITWIDTH = $clog2(BITMASK_LENGTH + 1),
  parameter int LANE_BITWIDTH  = $clog2(NUM_LANES + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                ivalid,
  output logic                                oready,
  input  logic [BITMASK_LENGTH-1:0]           bitmaskW,
  input  logic [BITMASK_LENGTH-1:0]           bitmaskA,
  output logic                                ovalid,
  input  logic                                iready,
  output logic [NUM_LANES*INDEX_BITWIDTH-1:0] indicesA,
  output logic [NUM_LANES*INDEX_BITWIDTH-1:0] indicesW,
  output logic [LANE_BITWIDTH-1:0]            laneCount,
  output logic [COUNT_BITWIDTH-1:0]           totalCount,
  output logic                                olast
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                      state_q, state_d;
  logic [BITMASK_LENGTH-1:0]   held_w_q, held_w_d;
  logic [BITMASK_LENGTH-1:0]   held_a_q, held_a_d;
  logic [COUNT_BITWIDTH-1:0]   cursor_q, cursor_d;

  logic                        held_valid;
  logic                        fire;
  logic                        accept;
  logic [INDEX_BITWIDTH-1:0]   entry_a [BITMASK_LENGTH];
  logic [INDEX_BITWIDTH-1:0]   entry_w [BITMASK_LENGTH];
  logic [COUNT_BITWIDTH-1:0]   match_count;
  logic [COUNT_BITWIDTH-1:0]   cnt_a, cnt_w;
  int                          base, total, remaining;

  assign held_valid = (state_q == EMIT);

  // Compaction: walk positions LSB first, writing each match into the next free slot.
  always_comb begin
    for (int k = 0; k < BITMASK_LENGTH; k++) begin
      entry_a[k] = '0;
      entry_w[k] = '0;
    end
    cnt_a       = '0;
    cnt_w       = '0;
    match_count = '0;
    for (int p = 0; p < BITMASK_LENGTH; p++) begin
      if (held_a_q[p] && held_w_q[p]) begin
        entry_a[match_count[INDEX_BITWIDTH-1:0]] = cnt_a[INDEX_BITWIDTH-1:0];
        entry_w[match_count[INDEX_BITWIDTH-1:0]] = cnt_w[INDEX_BITWIDTH-1:0];
        match_count = match_count + COUNT_BITWIDTH'(1);
      end
      cnt_a = cnt_a + COUNT_BITWIDTH'(held_a_q[p]);
      cnt_w = cnt_w + COUNT_BITWIDTH'(held_w_q[p]);
    end
  end

  // Beat view: everything is a function of registered state only, so no input reaches an output.
  always_comb begin
    indicesA   = '0;
    indicesW   = '0;
    laneCount  = '0;
    totalCount = '0;
    olast      = 1'b0;
    ovalid     = held_valid;
    base       = int'(cursor_q) * NUM_LANES;
    total      = held_valid ? int'(match_count) : 0;
    remaining  = total - base;
    for (int j = 0; j < NUM_LANES; j++) begin
      for (int k = 0; k < BITMASK_LENGTH; k++) begin
        if (k == base + j && k < total) begin
          indicesA[j*INDEX_BITWIDTH +: INDEX_BITWIDTH] = entry_a[k];
          indicesW[j*INDEX_BITWIDTH +: INDEX_BITWIDTH] = entry_w[k];
        end
      end
    end
    if (held_valid) begin
      totalCount = match_count;
      olast      = (base + NUM_LANES >= total);
      if (remaining > NUM_LANES)
        laneCount = LANE_BITWIDTH'(NUM_LANES);
      else if (remaining > 0)
        laneCount = LANE_BITWIDTH'(remaining);
    end
  end

  assign fire   = held_valid && iready;
  assign oready = !held_valid || (iready && olast);
  assign accept = ivalid && oready;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    held_w_d = held_w_q;
    held_a_d = held_a_q;
    cursor_d = cursor_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          held_w_d = bitmaskW;
          held_a_d = bitmaskA;
          cursor_d = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (fire) begin
          if (olast) begin
            cursor_d = '0;
            if (ivalid) begin
              held_w_d = bitmaskW;
              held_a_d = bitmaskA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cursor_d = cursor_q + COUNT_BITWIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      held_w_q <= '0;
      held_a_q <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      held_w_q <= held_w_d;
      held_a_q <= held_a_d;
      cursor_q <= cursor_d;
    end
  end

endmodule

// File: tb/tb_operand_matcher_stream.sv
// Directed bench for operand_matcher_stream (L=16, N=4): vector table plus
// hand-written backpressure, back-to-back and mid-burst reset sequences.
module tb_operand_matcher_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic        ivalid;
  logic        oready;
  logic [15:0] bitmaskW, bitmaskA;
  logic        ovalid;
  logic        iready;
  logic [15:0] indicesA, indicesW;
  logic [2:0]  laneCount;
  logic [4:0]  totalCount;
  logic        olast;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  operand_matcher_stream dut (
    .clock      (clock),
    .reset      (reset),
    .ivalid     (ivalid),
    .oready     (oready),
    .bitmaskW   (bitmaskW),
    .bitmaskA   (bitmaskA),
    .ovalid     (ovalid),
    .iready     (iready),
    .indicesA   (indicesA),
    .indicesW   (indicesW),
    .laneCount  (laneCount),
    .totalCount (totalCount),
    .olast      (olast)
  );

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] a;
    logic [2:0]  beats;
    logic [4:0]  total;
    logic [63:0] ia;   // beat b in bits [16b +: 16]
    logic [63:0] iw;
    logic [11:0] lc;   // beat b in bits [3b +: 3]
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ovalid"},     ovalid,     1'b0);
    check({tag, " oready"},     oready,     1'b1);
    check({tag, " olast"},      olast,      1'b0);
    check({tag, " laneCount"},  laneCount,  3'd0);
    check({tag, " totalCount"}, totalCount, 5'd0);
    check({tag, " indicesA"},   indicesA,   16'h0);
    check({tag, " indicesW"},   indicesW,   16'h0);
  endtask

  task automatic check_beat(input string tag, input vec_t v, input int b);
    string t;
    t = $sformatf("%s beat%0d", tag, b);
    check({t, " ovalid"},     ovalid,     1'b1);
    check({t, " indicesA"},   indicesA,   v.ia[b*16 +: 16]);
    check({t, " indicesW"},   indicesW,   v.iw[b*16 +: 16]);
    check({t, " laneCount"},  laneCount,  v.lc[b*3 +: 3]);
    check({t, " totalCount"}, totalCount, v.total);
    check({t, " olast"},      olast,      (b == int'(v.beats) - 1));
  endtask

  // Presents a pair for one edge; returns at the negedge where beat 0 is visible.
  task automatic load(input string tag, input vec_t v);
    @(negedge clock);
    bitmaskW = v.w;
    bitmaskA = v.a;
    ivalid   = 1'b1;
    iready   = 1'b1;
    check({tag, " oready at accept"}, oready, 1'b1);
    @(negedge clock);
    ivalid = 1'b0;
  endtask

  task automatic drain(input string tag, input vec_t v, input int from_b);
    for (int b = from_b; b < int'(v.beats); b++) begin
      check_beat(tag, v, b);
      check({tag, $sformatf(" oready beat%0d", b)}, oready, (b == int'(v.beats) - 1));
      @(negedge clock);
    end
    check_idle({tag, " after"});
  endtask

  initial begin
    vecs[0] = '{w: 16'hAAAA, a: 16'hFFF0, beats: 3'd2, total: 5'd6,
                ia: 64'h0000_0000_00B9_7531, iw: 64'h0000_0000_0076_5432,
                lc: {3'd0, 3'd0, 3'd2, 3'd4}};
    vecs[1] = '{w: 16'hFFFF, a: 16'hFFFF, beats: 3'd4, total: 5'd16,
                ia: 64'hFEDC_BA98_7654_3210, iw: 64'hFEDC_BA98_7654_3210,
                lc: {3'd4, 3'd4, 3'd4, 3'd4}};
    vecs[2] = '{w: 16'h00FF, a: 16'hFF00, beats: 3'd1, total: 5'd0,
                ia: 64'h0, iw: 64'h0, lc: 12'd0};
    vecs[3] = '{w: 16'h8000, a: 16'hFFFF, beats: 3'd1, total: 5'd1,
                ia: 64'h0000_0000_0000_000F, iw: 64'h0,
                lc: {3'd0, 3'd0, 3'd0, 3'd1}};
    vecs[4] = '{w: 16'h0F0F, a: 16'h3335, beats: 3'd1, total: 5'd4,
                ia: 64'h0000_0000_0000_5410, iw: 64'h0000_0000_0000_5420,
                lc: {3'd0, 3'd0, 3'd0, 3'd4}};

    reset    = 1'b1;
    ivalid   = 1'b0;
    iready   = 1'b0;
    bitmaskW = '0;
    bitmaskA = '0;
    @(negedge clock);
    @(negedge clock);
    check_idle("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load($sformatf("vec%0d", i), vecs[i]);
      drain($sformatf("vec%0d", i), vecs[i], 0);
    end

    // Backpressure: stall three cycles on beat 1 of the all-ones pair.
    load("stall", vecs[1]);
    check_beat("stall", vecs[1], 0);
    @(negedge clock);
    check_beat("stall", vecs[1], 1);
    iready = 1'b0;
    ivalid = 1'b1;            // must be ignored while stalled
    bitmaskW = 16'h0001;
    bitmaskA = 16'h0001;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      check_beat($sformatf("stall hold%0d", s), vecs[1], 1);
      check($sformatf("stall oready%0d", s), oready, 1'b0);
    end
    ivalid = 1'b0;
    iready = 1'b1;
    @(negedge clock);
    drain("stall", vecs[1], 2);

    // Back-to-back: next pair offered during the first transaction's last-beat fire.
    load("b2b", vecs[0]);
    check_beat("b2b first", vecs[0], 0);
    @(negedge clock);
    check_beat("b2b first", vecs[0], 1);
    check("b2b oready on last", oready, 1'b1);
    bitmaskW = vecs[1].w;
    bitmaskA = vecs[1].a;
    ivalid   = 1'b1;
    @(negedge clock);
    ivalid = 1'b0;
    drain("b2b second", vecs[1], 0);

    // Reset during beat 2, then a fresh transaction starts from cursor 0.
    load("rst", vecs[1]);
    check_beat("rst", vecs[1], 0);
    @(negedge clock);
    check_beat("rst", vecs[1], 1);
    @(negedge clock);
    check_beat("rst", vecs[1], 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("rst mid-burst");
    load("rst restart", vecs[0]);
    drain("rst restart", vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
